// File: rtl/qcs_dyn_pre_gen_rd_sched.sv
// Read scheduler for the dynamic preamble generator: walks STF then LTF repetitions,
// issuing paced, ready-gated sample reads and reporting completion or config errors.
module qcs_dyn_pre_gen_rd_sched #(
    parameter  int SEG_LEN = 80,
    parameter  int RW      = 4,
    parameter  int PW      = 4,
    localparam int AW      = $clog2(SEG_LEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [RW-1:0] cfg_stf_rep,
    input  logic [RW-1:0] cfg_ltf_rep,
    input  logic [PW-1:0] cfg_pace,
    input  logic          dst_rdy,
    output logic          nhtp_re,
    output logic [AW-1:0] rd_addr,
    output logic [1:0]    seg_sel,
    output logic          sym_last,
    output logic          busy,
    output logic          done,
    output logic          err_cfg
);

    typedef enum logic [1:0] {S_IDLE, S_STF, S_LTF, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(SEG_LEN - 1);

    state_t        state_q,    state_d;
    logic [AW-1:0] rd_addr_q,  rd_addr_d;
    logic [RW-1:0] rep_cnt_q,  rep_cnt_d;
    logic [PW-1:0] pace_cnt_q, pace_cnt_d;
    logic [RW-1:0] stf_rep_q,  stf_rep_d;
    logic [RW-1:0] ltf_rep_q,  ltf_rep_d;
    logic [PW-1:0] pace_cfg_q, pace_cfg_d;
    logic          err_cfg_q,  err_cfg_d;
    logic          in_seg;
    logic          rd_fire;

    assign in_seg  = (state_q == S_STF) || (state_q == S_LTF);
    assign rd_fire = in_seg && (pace_cnt_q == '0) && dst_rdy && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            rep_cnt_q  <= '0;
            pace_cnt_q <= '0;
            stf_rep_q  <= '0;
            ltf_rep_q  <= '0;
            pace_cfg_q <= '0;
            err_cfg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rep_cnt_q  <= rep_cnt_d;
            pace_cnt_q <= pace_cnt_d;
            stf_rep_q  <= stf_rep_d;
            ltf_rep_q  <= ltf_rep_d;
            pace_cfg_q <= pace_cfg_d;
            err_cfg_q  <= err_cfg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rep_cnt_d  = rep_cnt_q;
        pace_cnt_d = pace_cnt_q;
        stf_rep_d  = stf_rep_q;
        ltf_rep_d  = ltf_rep_q;
        pace_cfg_d = pace_cfg_q;
        err_cfg_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in the same cycle drops the start request entirely
                if (start && !abort) begin
                    stf_rep_d  = cfg_stf_rep;
                    ltf_rep_d  = cfg_ltf_rep;
                    pace_cfg_d = cfg_pace;
                    rd_addr_d  = '0;
                    pace_cnt_d = '0;
                    if (cfg_stf_rep != '0) begin
                        state_d   = S_STF;
                        rep_cnt_d = cfg_stf_rep;
                    end else if (cfg_ltf_rep != '0) begin
                        state_d   = S_LTF;
                        rep_cnt_d = cfg_ltf_rep;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            S_STF, S_LTF: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    rd_addr_d  = '0;
                    rep_cnt_d  = '0;
                    pace_cnt_d = '0;
                end else if (pace_cnt_q != '0) begin
                    pace_cnt_d = pace_cnt_q - PW'(1);
                end else if (dst_rdy) begin
                    pace_cnt_d = pace_cfg_q;
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
                        rep_cnt_d = rep_cnt_q - RW'(1);
                        if (rep_cnt_q == RW'(1)) begin
                            // segment exhausted: enter LTF fresh, or finish
                            pace_cnt_d = '0;
                            if ((state_q == S_STF) && (ltf_rep_q != '0)) begin
                                state_d   = S_LTF;
                                rep_cnt_d = ltf_rep_q;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        nhtp_re  = rd_fire;
        rd_addr  = rd_addr_q;
        sym_last = rd_fire && (rd_addr_q == LAST_ADDR);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE) && !abort;
        err_cfg  = err_cfg_q;
        case (state_q)
            S_STF:   seg_sel = 2'd1;
            S_LTF:   seg_sel = 2'd2;
            default: seg_sel = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_qcs_dyn_pre_gen_rd_sched.sv
// Bench for the preamble read scheduler: table of runs checked against a per-read
// scoreboard of expected cycle, segment, address and last flag, plus idle-state corner cases.
module tb_qcs_dyn_pre_gen_rd_sched;

    localparam int SEG_LEN = 16;
    localparam int AW      = $clog2(SEG_LEN);

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [3:0]    cfg_stf_rep;
    logic [3:0]    cfg_ltf_rep;
    logic [3:0]    cfg_pace;
    logic          dst_rdy;
    logic          nhtp_re;
    logic [AW-1:0] rd_addr;
    logic [1:0]    seg_sel;
    logic          sym_last;
    logic          busy;
    logic          done;
    logic          err_cfg;

    qcs_dyn_pre_gen_rd_sched #(.SEG_LEN(SEG_LEN), .RW(4), .PW(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_stf_rep(cfg_stf_rep), .cfg_ltf_rep(cfg_ltf_rep), .cfg_pace(cfg_pace),
        .dst_rdy(dst_rdy), .nhtp_re(nhtp_re), .rd_addr(rd_addr), .seg_sel(seg_sel),
        .sym_last(sym_last), .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    typedef struct {
        int cyc;
        int seg;
        int addr;
        int last;
    } exp_t;

    typedef struct {
        int stf;
        int ltf;
        int pace;
        int stall_from;
        int stall_len;
        int inj_start;
        int abort_at;
        int rst_at;
        int exp_reads;
        int exp_done;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rd_seen  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && nhtp_re) begin
            rd_seen++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: got addr %0d seg %0d at cycle %0d, expected no read",
                         rd_addr, seg_sel, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.seg != int'(seg_sel) || e.addr != int'(rd_addr) ||
                    e.last != int'(sym_last)) begin
                    failures++;
                    $display("FAIL read: got cyc=%0d seg=%0d addr=%0d last=%0d expected cyc=%0d seg=%0d addr=%0d last=%0d",
                             cyc, seg_sel, rd_addr, sym_last, e.cyc, e.seg, e.addr, e.last);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_nhtp_re"}, nhtp_re, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_seg_sel"}, seg_sel, 0);
        chk({tag, "_sym_last"}, sym_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_cfg"}, err_cfg, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int t;
        int cut;
        int pushed;
        int got_done;
        bit finished;
        bit stop;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        n           = cyc;
        start       = 1'b1;
        cfg_stf_rep = 4'(v.stf);
        cfg_ltf_rep = 4'(v.ltf);
        cfg_pace    = 4'(v.pace);
        dst_rdy     = 1'b1;
        rd_seen     = 0;
        cut         = (v.abort_at != 0) ? v.abort_at : v.rst_at;
        t           = n + 1;
        pushed      = 0;
        stop        = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            for (int r = 0; r < ((s == 1) ? v.stf : v.ltf); r++) begin
                for (int a = 0; a < SEG_LEN; a++) begin
                    if (v.stall_len > 0 && t >= n + v.stall_from && t < n + v.stall_from + v.stall_len)
                        t = n + v.stall_from + v.stall_len;
                    if (cut > 0 && t >= n + cut) stop = 1'b1;
                    if (!stop) begin
                        sb.push_back('{t, s, a, (a == SEG_LEN - 1) ? 1 : 0});
                        pushed++;
                    end
                    t += v.pace + 1;
                end
            end
        end
        chk({tag, "_model_reads"}, pushed, v.exp_reads);

        got_done = -1;
        finished = 1'b0;
        for (int k = 0; k < 300 && !finished; k++) begin
            @(posedge clk); #1;
            start = (v.inj_start != 0 && cyc == n + v.inj_start);
            if (start) begin
                cfg_stf_rep = 4'd1;
                cfg_ltf_rep = 4'd0;
                cfg_pace    = 4'd5;
            end
            dst_rdy = !(v.stall_len > 0 && cyc >= n + v.stall_from &&
                        cyc < n + v.stall_from + v.stall_len);
            if (v.rst_at != 0 && cyc == n + v.rst_at) begin
                reset_n = 1'b0;
                #1;
                check_all_zero({tag, "_rst"});
                finished = 1'b1;
            end else begin
                abort = (v.abort_at != 0 && cyc == n + v.abort_at);
                @(negedge clk);
                if (abort) begin
                    chk({tag, "_abort_re"}, nhtp_re, 0);
                    chk({tag, "_abort_done"}, done, 0);
                    @(posedge clk); #1;
                    abort = 1'b0;
                    @(negedge clk);
                    chk({tag, "_abort_busy"}, busy, 0);
                    chk({tag, "_abort_nodone"}, done, 0);
                    finished = 1'b1;
                end else if (done) begin
                    got_done = cyc - n;
                    chk({tag, "_done_busy"}, busy, 1);
                    finished = 1'b1;
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        dst_rdy = 1'b1;

        if (v.rst_at != 0) begin
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
        end else if (v.abort_at == 0) begin
            chk({tag, "_done_cycle"}, got_done, v.exp_done);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_busy_after"}, busy, 0);
            chk({tag, "_done_after"}, done, 0);
        end
        chk({tag, "_read_count"}, rd_seen, v.exp_reads);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        //          stf ltf pace sfrom slen inj abort rst reads done
        vecs[0]  = '{2, 1, 0, 0, 0, 0,  0,  0,  48, 49};
        vecs[1]  = '{1, 0, 3, 0, 0, 0,  0,  0,  16, 62};
        vecs[2]  = '{2, 1, 0, 5, 5, 0,  0,  0,  48, 54};
        vecs[3]  = '{2, 1, 0, 0, 0, 0,  10, 0,  9,  0};
        vecs[4]  = '{2, 1, 0, 0, 0, 0,  0,  0,  48, 49};
        vecs[5]  = '{2, 1, 0, 0, 0, 20, 0,  0,  48, 49};
        vecs[6]  = '{2, 1, 0, 0, 0, 0,  0,  20, 19, 0};
        vecs[7]  = '{2, 1, 0, 0, 0, 0,  0,  0,  48, 49};
        vecs[8]  = '{0, 1, 1, 0, 0, 0,  0,  0,  16, 32};
        vecs[9]  = '{0, 2, 0, 0, 0, 0,  0,  0,  32, 33};
        vecs[10] = '{1, 1, 0, 0, 0, 0,  0,  0,  32, 33};
        vecs[11] = '{3, 0, 2, 0, 0, 0,  0,  0,  48, 143};

        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_stf_rep = 4'd0;
        cfg_ltf_rep = 4'd0;
        cfg_pace    = 4'd0;
        dst_rdy     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // both repetition counts zero: error pulse, stay idle
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("errcfg_pulse", err_cfg, 1);
        chk("errcfg_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        chk("errcfg_clear", err_cfg, 0);
        chk("errcfg_busy2", busy, 0);

        // abort together with start in idle wins
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        cfg_stf_rep = 4'd2;
        cfg_ltf_rep = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", busy, 0);
        chk("abort_start_re", nhtp_re, 0);
        chk("abort_start_err", err_cfg, 0);

        // abort alone in idle does nothing
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        @(posedge clk); #1 abort = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
